// File: rtl/pwm_pkg.sv
// pwm_pkg: constants shared by the PWM generators and the PWM capture block.
package pwm_pkg;
   localparam int PWM_WIDTH = 12;
   typedef enum logic [1:0] {ACQ = 2'd0, MEAS_HIGH = 2'd1, MEAS_LOW = 2'd2} cap_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus history flop with rise/fall detect.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic s,
   output logic rise,
   output logic fall
);
   logic meta, prev;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         s    <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= d;
         s    <= meta;
         prev <= s;
      end
   end
   assign rise = s & ~prev;
   assign fall = ~s & prev;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of each PWM cycle in clocks,
// reporting a stuck level by timeout when no rising edge arrives.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwm_in,
   output logic [CNT_WIDTH-1:0] high_cnt,
   output logic [CNT_WIDTH-1:0] period_cnt,
   output logic                 valid,
   output logic                 stuck,
   output logic                 level
);
   localparam logic [CNT_WIDTH-1:0] MAX = '1;
   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   logic s, rise, fall, pub, tmo;
   cap_state_t state, state_nx;
   logic [CNT_WIDTH-1:0] cnt, cnt_nx, hi, hi_nx;
   sync_edge u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pwm_in),
      .s    (s),
      .rise (rise),
      .fall (fall)
   );
   // A rise always wins over the timeout, so a period of exactly MAX still publishes.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hi_nx    = hi;
      pub      = 1'b0;
      tmo      = 1'b0;
      if (rise) begin
         cnt_nx   = ONE;
         hi_nx    = ONE;
         state_nx = MEAS_HIGH;
         pub      = (state == MEAS_LOW);
      end else if (cnt == MAX) begin
         tmo      = !(state == ACQ && stuck);
         state_nx = ACQ;
      end else begin
         cnt_nx = cnt + 1'b1;
         if (state == MEAS_HIGH) begin
            if (fall) state_nx = MEAS_LOW;
            else hi_nx = hi + 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACQ;
         cnt        <= '0;
         hi         <= '0;
         high_cnt   <= '0;
         period_cnt <= '0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
         level      <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         hi    <= hi_nx;
         valid <= pub | tmo;
         if (pub) begin
            period_cnt <= cnt;
            high_cnt   <= hi;
            stuck      <= 1'b0;
         end else if (tmo) begin
            period_cnt <= MAX;
            high_cnt   <= s ? MAX : '0;
            level      <= s;
            stuck      <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus with scoreboard queues for a 16-bit and an 8-bit capture instance.
module tb_pwm_capture;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst16_n, pwm16, rst8_n, pwm8;
   logic [15:0] hc16, pc16;
   logic [7:0]  hc8, pc8;
   logic v16, st16, lv16, v8, st8, lv8;
   pwm_capture #(.CNT_WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst16_n), .pwm_in(pwm16), .high_cnt(hc16), .period_cnt(pc16),
      .valid(v16), .stuck(st16), .level(lv16)
   );
   pwm_capture #(.CNT_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst8_n), .pwm_in(pwm8), .high_cnt(hc8), .period_cnt(pc8),
      .valid(v8), .stuck(st8), .level(lv8)
   );
   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] per;
      logic        st;
      logic        lv;
   } exp_t;
   exp_t q16[$], q8[$];
   exp_t e16, e8;
   int errors = 0, checks = 0, cyc = 0, last16 = -1, n8 = 0;
   int prev16 = 0, prev8h = 0, prev8l = 0;
   bit have16 = 0, have8 = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst16_n) last16 = -1;
      else if (v16) begin
         chk("v16_expected", 32'(q16.size() != 0), 1);
         if (q16.size() != 0) begin
            e16 = q16.pop_front();
            chk("hi16", 32'(hc16), 32'(e16.hi));
            chk("per16", 32'(pc16), 32'(e16.per));
            chk("stuck16", 32'(st16), 32'(e16.st));
            chk("level16", 32'(lv16), 32'(e16.lv));
         end
         if (last16 >= 0) chk("gap16", cyc - last16, 4096);
         last16 = cyc;
      end
   end

   always @(negedge clk) begin
      if (rst8_n && v8) begin
         n8 = n8 + 1;
         chk("v8_expected", 32'(q8.size() != 0), 1);
         if (q8.size() != 0) begin
            e8 = q8.pop_front();
            chk("hi8", 32'(hc8), 32'(e8.hi));
            chk("per8", 32'(pc8), 32'(e8.per));
            chk("stuck8", 32'(st8), 32'(e8.st));
            chk("level8", 32'(lv8), 32'(e8.lv));
         end
      end
   end

   task automatic gen16(input int d);
      if (have16) q16.push_back(exp_t'{hi: 16'(prev16), per: 16'd4096, st: 1'b0, lv: 1'b0});
      pwm16 = 1'b1;
      repeat (d) @(negedge clk);
      pwm16 = 1'b0;
      repeat (4096 - d) @(negedge clk);
      prev16 = d;
      have16 = 1;
   endtask

   task automatic gen8(input int h, input int l);
      if (have8) q8.push_back(exp_t'{hi: 16'(prev8h), per: 16'(prev8h + prev8l), st: 1'b0, lv: 1'b1});
      pwm8 = 1'b1;
      repeat (h) @(negedge clk);
      pwm8 = 1'b0;
      repeat (l) @(negedge clk);
      prev8h = h;
      prev8l = l;
      have8 = 1;
   endtask

   task automatic wait8(input string tag, input int n, input int bound);
      int k = 0;
      while (n8 < n && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(tag, n8, n);
   endtask

   initial begin
      rst16_n = 1'b0;
      rst8_n  = 1'b0;
      pwm16   = 1'b0;
      pwm8    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hi16", 32'(hc16), 0);
      chk("rst_per16", 32'(pc16), 0);
      chk("rst_valid16", 32'(v16), 0);
      chk("rst_stuck16", 32'(st16), 0);
      chk("rst_level16", 32'(lv16), 0);
      chk("rst_valid8", 32'(v8), 0);
      chk("rst_stuck8", 32'(st8), 0);
      // Input held low from reset: one timeout, then silence.
      q8.push_back(exp_t'{hi: 16'd0, per: 16'd255, st: 1'b1, lv: 1'b0});
      rst8_n = 1'b1;
      wait8("stuck_low_seen", 1, 400);
      repeat (600) @(negedge clk);
      chk("stuck_low_once", n8, 1);
      // Stuck high, then recovery with a 10/20 waveform.
      q8.push_back(exp_t'{hi: 16'd255, per: 16'd255, st: 1'b1, lv: 1'b1});
      pwm8 = 1'b1;
      wait8("stuck_high_seen", 2, 400);
      pwm8 = 1'b0;
      repeat (20) @(negedge clk);
      repeat (4) gen8(10, 20);
      q8.push_back(exp_t'{hi: 16'd10, per: 16'd30, st: 1'b0, lv: 1'b1});
      pwm8 = 1'b1;
      repeat (5) @(negedge clk);
      chk("recover_count8", n8, 6);
      chk("recover_stuck8", 32'(st8), 0);
      rst8_n = 1'b0;
      pwm8 = 1'b0;
      // 16-bit: steady duty, sweep, and duty change.
      rst16_n = 1'b1;
      repeat (5) @(negedge clk);
      repeat (4) gen16(1024);
      gen16(1);
      gen16(4095);
      gen16(1024);
      gen16(3000);
      gen16(3000);
      q16.push_back(exp_t'{hi: 16'd3000, per: 16'd4096, st: 1'b0, lv: 1'b0});
      pwm16 = 1'b1;
      repeat (100) @(negedge clk);
      chk("pre_reset_empty16", q16.size(), 0);
      // Reset mid-period discards the partial measurement immediately.
      rst16_n = 1'b0;
      #1;
      chk("midrst_hi16", 32'(hc16), 0);
      chk("midrst_per16", 32'(pc16), 0);
      chk("midrst_valid16", 32'(v16), 0);
      chk("midrst_stuck16", 32'(st16), 0);
      have16 = 0;
      pwm16 = 1'b0;
      repeat (3) @(negedge clk);
      rst16_n = 1'b1;
      repeat (10) @(negedge clk);
      repeat (3) gen16(500);
      q16.push_back(exp_t'{hi: 16'd500, per: 16'd4096, st: 1'b0, lv: 1'b0});
      pwm16 = 1'b1;
      repeat (5) @(negedge clk);
      pwm16 = 1'b0;
      chk("final_empty16", q16.size(), 0);
      chk("final_empty8", q8.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures a single-bit PWM waveform, such as the RGB LED drive signals produced by our PWM generators or an external PWM source, and reports the high time and period of each complete cycle in clock cycles. It is the receive/decode counterpart of the counter-compare PWM generators. It sits between an input pin or loopback net and status logic that consumes the measured duty. Stuck-high and stuck-low inputs are detected by timeout and reported instead of hanging.

## Interface
- CNT_WIDTH, 16: width of the internal counters and the measurement outputs; MAX = 2^CNT_WIDTH-1.
- clk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous, active-low reset.
- pwm_in  in  1  asynchronous PWM input.
- high_cnt  out  CNT_WIDTH  clocks pwm_in was high in the last measured period.
- period_cnt  out  CNT_WIDTH  clocks from one rising edge to the next.
- valid  out  1  one-cycle pulse when high_cnt/period_cnt/stuck/level update.
- stuck  out  1  input had no rising edge for MAX clocks.
- level  out  1  synchronized level of pwm_in when stuck was last set.

## Operation
- Synchronizer: 2 flops, reset 0, then a 1-flop history register, reset 0.
- Edge detect on synchronized signal s: rise = s & ~s_prev; fall = ~s & s_prev.
- Counters: cnt (period), hi (high time), both CNT_WIDTH bits, reset 0.
- FSM states: ACQ (reset state), MEAS_HIGH, MEAS_LOW.
- ACQ:
  - rise: cnt<=1, hi<=1, go to MEAS_HIGH. No publish.
  - otherwise, if cnt<MAX: cnt++.
  - cnt==MAX without rise: timeout (see below). Applies only if not already stuck; otherwise hold.
- MEAS_HIGH: cnt++, hi++ each cycle. On fall: cnt++, hi unchanged, go to MEAS_LOW.
- MEAS_LOW:
  - rise: publish (period_cnt<=cnt, high_cnt<=hi, stuck<=0, valid<=1), cnt<=1, hi<=1, go to MEAS_HIGH.
  - otherwise: cnt++.
- The rising-edge cycle counts as cycle 1 of the new period, high. A generator of period 4096 and compare value d therefore reads high_cnt=d, period_cnt=4096.
- Timeout:
  - Trigger: cnt==MAX in any state with no rise this cycle.
  - Publish: period_cnt<=MAX, high_cnt <= s ? MAX : 0, level<=s, stuck<=1, valid<=1.
  - Then go to ACQ, cnt held at MAX. No further valid until a rise.
- Simultaneous rise and cnt==MAX: rise wins and a normal publish is made with period_cnt=MAX.
- Arithmetic: cnt and hi never wrap. Timeout fires before overflow, and hi ≤ cnt always.
- Pulses or gaps shorter than one clk period may be missed. No debounce.

## Timing
- Reset values: high_cnt=0, period_cnt=0, valid=0, stuck=0, level=0, FSM=ACQ.
- Reset asserted mid-measurement discards the partial period immediately, with no valid. After release, the first publish follows the second observed rising edge.
- Latency: if pwm_in is first sampled high at clk edge N, rise is seen combinationally after edge N+1. Outputs and valid update at edge N+2. valid is high for exactly one cycle.
- Outputs are registered and hold between valid pulses.
- Minimum resolvable high or low time is 1 clock; each period publishes exactly once.

## Structure
- Shared package pwm_pkg:
  - PWM_WIDTH=12, shared with the generators.
  - FSM state encoding constants.
- Sub-module sync_edge: the 2-flop synchronizer plus history flop, outputting s, rise and fall. The top holds the FSM, counters and output registers.

## Test plan
- Generator at period 4096, d=1024, CNT_WIDTH=16: after the second rise, every valid gives high_cnt=1024, period_cnt=4096, stuck=0.
- Duty sweep d=1, d=4095: high_cnt=1 / 4095, period_cnt=4096. valid pulses exactly 4096 clocks apart.
- pwm_in held 0 from reset, CNT_WIDTH=8:
  - one valid 255 clocks after reset release, with stuck=1, level=0, high_cnt=0, period_cnt=255.
  - no further valid.
- Stuck-high recovery, CNT_WIDTH=8:
  - pwm_in rises, then held 1: a timeout publishes high_cnt=255, level=1, stuck=1.
  - A subsequent 10-high/20-low waveform: stuck clears on the first complete period, which reads high_cnt=10, period_cnt=30.
- rst_n pulsed low mid-period: outputs return to 0 at once. The first post-reset valid appears 2 cycles after the second sampled rise, with correct values.
- Duty changes 1024→3000 between periods: consecutive valids report 1024 then 3000, with period_cnt=4096 each.
